// File: rtl/feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : feeder_pkg
// Description : Shared types, opcode constants and helpers for instr_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

    localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE = 7'b0100011;

    function automatic logic is_mem_op(input logic [31:0] instr);
        return (instr[6:0] == c_OPC_LOAD) || (instr[6:0] == c_OPC_STORE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/feeder_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : feeder_prog_mem
// Description : Program buffer, one synchronous write port and one
//               combinational read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module feeder_prog_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/instr_feeder.sv
`default_nettype none
// ============================================================================
// Module      : instr_feeder
// Description : Issues a stored RV32 program to a processor shim over a
//               valid/ready handshake, with idle bubbles after loads/stores.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_feeder
    import feeder_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int BUBBLE_CYCLES = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       prog_we_i,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr_i,
    input  logic [31:0]                prog_data_i,
    input  logic [$clog2(DEPTH):0]     prog_len_i,
    input  logic                       start_i,
    output logic [31:0]                instr_o,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [$clog2(DEPTH):0]     pc_o,
    output logic                       mem_op_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [3:0]  c_BUB_LAST = 4'(BUBBLE_CYCLES - 1);

    feeder_state_t r_state;
    feeder_state_t w_next_state;

    logic [AW:0]  r_pc;
    logic [AW:0]  r_len;
    logic [3:0]   r_bub;

    logic [31:0]  w_rd;
    logic [AW:0]  w_pc_inc;
    logic [AW:0]  w_len_clamped;
    logic         w_idle_like;
    logic         w_prog_we;
    logic         w_xfer;
    logic         w_is_mem;
    logic         w_last;

    assign w_idle_like   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_prog_we     = prog_we_i && w_idle_like;
    assign w_xfer        = (r_state == ST_ISSUE) && instr_ready_i;
    assign w_is_mem      = is_mem_op(w_rd);
    assign w_pc_inc      = r_pc + 1'b1;
    assign w_last        = (w_pc_inc == r_len);
    assign w_len_clamped = (prog_len_i > c_DEPTH) ? c_DEPTH : prog_len_i;

    // Same-cycle write+start works because the read port is combinational:
    // the word lands at the edge that also moves the FSM into ISSUE.
    feeder_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk_i),
        .i_we    (w_prog_we),
        .i_waddr (prog_addr_i),
        .i_wdata (prog_data_i),
        .i_raddr (r_pc[AW-1:0]),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_next_state = (prog_len_i == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_xfer) begin
                    if (w_last) begin
                        w_next_state = ST_DONE;
                    end else if (w_is_mem) begin
                        w_next_state = ST_BUBBLE;
                    end else begin
                        w_next_state = ST_ISSUE;
                    end
                end
            end
            ST_BUBBLE: begin
                if (r_bub == c_BUB_LAST) begin
                    w_next_state = ST_ISSUE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_valid_o = 1'b0;
        instr_o       = '0;
        mem_op_o      = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                instr_valid_o = 1'b1;
                instr_o       = w_rd;
                mem_op_o      = w_xfer && w_is_mem;
                busy_o        = 1'b1;
            end
            ST_BUBBLE: busy_o = 1'b1;
            ST_DONE:   done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc  <= '0;
            r_len <= '0;
            r_bub <= '0;
        end else begin
            if (w_idle_like && start_i) begin
                r_len <= w_len_clamped;
                r_pc  <= '0;
            end else if (w_xfer) begin
                r_pc  <= w_pc_inc;
            end
            // Counter is held at zero outside BUBBLE so every bubble starts fresh.
            if (r_state == ST_BUBBLE) begin
                r_bub <= r_bub + 1'b1;
            end else begin
                r_bub <= '0;
            end
        end
    end

    assign pc_o = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_feeder
// Description : Self-checking bench for instr_feeder (DEPTH=8, 1 bubble).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_feeder;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          prog_we_i;
    logic [AW-1:0] prog_addr_i;
    logic [31:0]   prog_data_i;
    logic [AW:0]   prog_len_i;
    logic          start_i;
    logic [31:0]   instr_o;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [AW:0]   pc_o;
    logic          mem_op_o;
    logic          busy_o;
    logic          done_o;

    instr_feeder #(
        .DEPTH         (DEPTH),
        .BUBBLE_CYCLES (1)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .prog_we_i     (prog_we_i),
        .prog_addr_i   (prog_addr_i),
        .prog_data_i   (prog_data_i),
        .prog_len_i    (prog_len_i),
        .start_i       (start_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .pc_o          (pc_o),
        .mem_op_o      (mem_op_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0][31:0] prog;
        int len;
        int stall_pc;
        int stall_n;
        int exp_xfers;
        int exp_mem;
        int exp_done;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit ref_mem(input logic [31:0] w);
        return (w[6:0] == 7'h03) || (w[6:0] == 7'h23);
    endfunction

    function automatic vec_t mk(input logic [31:0] a, b, c, d, e, f, g, h,
                                input int len, spc, sn, xf, mem, dn);
        vec_t v;
        v.prog[0] = a; v.prog[1] = b; v.prog[2] = c; v.prog[3] = d;
        v.prog[4] = e; v.prog[5] = f; v.prog[6] = g; v.prog[7] = h;
        v.len = len; v.stall_pc = spc; v.stall_n = sn;
        v.exp_xfers = xf; v.exp_mem = mem; v.exp_done = dn;
        return v;
    endfunction

    // Loads the program (word 0 written together with start), runs it and scores it.
    task automatic run(input vec_t v, input bit do_load, input bit busy_write, input string tag);
        int k, n, xfers, mems, done_at, stalled, bad_idle, bad_busy;
        bit stall_now;
        logic [31:0] w;
        k = 0; xfers = 0; mems = 0; done_at = -1; stalled = 0; bad_idle = 0; bad_busy = 0;
        if (do_load) begin
            for (int i = 1; i < DEPTH; i++) begin
                @(negedge clk_i);
                prog_we_i = 1'b1; prog_addr_i = AW'(i); prog_data_i = v.prog[i];
            end
        end
        @(negedge clk_i);
        prog_we_i   = do_load;
        prog_addr_i = '0;
        prog_data_i = v.prog[0];
        start_i     = 1'b1;
        prog_len_i  = (AW+1)'(v.len);
        n = (v.len > DEPTH) ? DEPTH : v.len;
        for (int i = 0; i < n; i++) exp_q.push_back(v.prog[i]);
        while (done_at < 0) begin
            @(negedge clk_i);
            k++;
            start_i = 1'b0;
            prog_we_i = 1'b0;
            if (busy_write && k == 1) begin
                prog_we_i = 1'b1; prog_addr_i = '0; prog_data_i = 32'h00000093;
            end
            stall_now = (v.stall_pc >= 0) && (stalled < v.stall_n) && instr_valid_o
                        && (int'(pc_o) == v.stall_pc);
            instr_ready_i = !stall_now;
            if (stall_now && stalled == 0) begin
                start_i = 1'b1; prog_len_i = 1;
            end
            if (stall_now) stalled++;
            #1;
            if (instr_valid_o) begin
                if (exp_q.size() == 0) begin
                    check({tag, ".extra_xfer"}, instr_o, 64'hDEAD);
                end else if (stall_now) begin
                    check({tag, ".stall_instr"}, instr_o, exp_q[0]);
                    check({tag, ".stall_pc"}, pc_o, xfers);
                    check({tag, ".stall_memop"}, mem_op_o, 0);
                end else begin
                    w = exp_q.pop_front();
                    check({tag, ".instr"}, instr_o, w);
                    check({tag, ".pc"}, pc_o, xfers);
                    check({tag, ".memop"}, mem_op_o, ref_mem(w));
                    xfers++;
                    if (mem_op_o) mems++;
                end
            end else begin
                if (instr_o != 0 || mem_op_o) bad_idle++;
            end
            if (busy_o === done_o) bad_busy++;
            if (done_o) done_at = k;
            if (k >= 100 && done_at < 0) begin
                check({tag, ".timeout"}, 0, 1);
                done_at = k;
            end
        end
        check({tag, ".xfers"}, xfers, v.exp_xfers);
        check({tag, ".mem_ops"}, mems, v.exp_mem);
        check({tag, ".done_cycle"}, done_at, v.exp_done);
        check({tag, ".drain"}, exp_q.size(), 0);
        check({tag, ".final_pc"}, pc_o, n);
        check({tag, ".idle_out"}, bad_idle, 0);
        check({tag, ".busy_done"}, bad_busy, 0);
        exp_q.delete();
        instr_ready_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
        prog_len_i = '0; start_i = 1'b0; instr_ready_i = 1'b1;

        tbl[0] = mk(32'h00002083, 32'h00102223, 32'h00402103, 32'h00000093,
                    32'h00500293, 32'h00600313, 32'h00700393, 32'h00800413,
                    4, -1, 0, 4, 3, 8);
        tbl[1] = mk(32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213,
                    32'h00500293, 32'h00600313, 32'h00700393, 32'h00800413,
                    4, -1, 0, 4, 0, 5);
        tbl[2] = mk(32'h01100093, 32'h01200113, 32'h01300193, 32'h01400213,
                    32'h01500293, 32'h01600313, 32'h01700393, 32'h01800413,
                    0, -1, 0, 0, 0, 1);
        tbl[3] = mk(32'h02100093, 32'h02200113, 32'h02300193, 32'h02400213,
                    32'h02500293, 32'h02600313, 32'h02700393, 32'h02800413,
                    12, -1, 0, 8, 0, 9);
        tbl[4] = mk(32'h03100093, 32'h00002083, 32'h00102223, 32'h03400213,
                    32'h03500293, 32'h03600313, 32'h03700393, 32'h03800413,
                    3, -1, 0, 3, 2, 5);
        tbl[5] = mk(32'h04100093, 32'h04200113, 32'h04300193, 32'h04400213,
                    32'h04500293, 32'h04600313, 32'h04700393, 32'h04800413,
                    5, 2, 5, 5, 0, 11);

        repeat (2) @(negedge clk_i);
        #1;
        check("rst.valid", instr_valid_o, 0);
        check("rst.instr", instr_o, 0);
        check("rst.pc", pc_o, 0);
        check("rst.memop", mem_op_o, 0);
        check("rst.busy", busy_o, 0);
        check("rst.done", done_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int t = 0; t < 6; t++) run(tbl[t], 1'b1, 1'b0, $sformatf("vec%0d", t));

        // Write while busy must be dropped; rerun without reloading sees the old word.
        run(tbl[0], 1'b1, 1'b1, "busywr");
        run(tbl[0], 1'b0, 1'b0, "busywr_rerun");

        // Asynchronous reset mid-issue, then rerun from pc 0 with the same program.
        run(tbl[1], 1'b1, 1'b0, "rst_load");
        @(negedge clk_i);
        start_i = 1'b1; prog_len_i = 4;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("midrst.pre_pc", pc_o, 1);
        check("midrst.pre_valid", instr_valid_o, 1);
        rst_i = 1'b1;
        #1;
        check("midrst.valid", instr_valid_o, 0);
        check("midrst.instr", instr_o, 0);
        check("midrst.pc", pc_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        run(tbl[1], 1'b0, 1'b0, "midrst_rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
